// File: rtl/nn_fp_pkg.sv
// rtl/nn_fp_pkg.sv - shared floating-point field constants and reduction FSM states
// Purpose : default float format, field-slice positions for that format,
//           FSM state encoding and an index-width helper used by the
//           float_argmax reduction block.
// Ports   : none (package).
package nn_fp_pkg;

  localparam int DEF_EXP_W    = 8;
  localparam int DEF_MAN_W    = 23;
  localparam int DEF_W        = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int DEF_SIGN_BIT = DEF_W - 1;
  localparam int DEF_EXP_MSB  = DEF_W - 2;
  localparam int DEF_EXP_LSB  = DEF_MAN_W;
  localparam int DEF_MAN_MSB  = DEF_MAN_W - 1;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_RESULT  = 1'b1
  } state_e;

  // Index width for n elements, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_order_cmp.sv
// rtl/fp_order_cmp.sv - combinational sign-magnitude float ordering comparator
// Purpose : orders two {sign, exp, man} values; +0 and -0 compare equal.
// Ports   : a, b    - operands (W = 1+EXP_W+MAN_W bits)
//           a_gt_b  - a strictly greater than b
//           a_eq_b  - a equal to b (bitwise, or both are zero of either sign)
//           a_nan   - a is NaN (exp all ones, man non-zero)
//           b_nan   - b is NaN
module fp_order_cmp #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_nan,
  output logic         b_nan
);

  logic             a_sign;
  logic             b_sign;
  logic [W-2:0]     a_mag;
  logic [W-2:0]     b_mag;
  logic             both_zero;

  assign a_sign = a[W-1];
  assign b_sign = b[W-1];
  assign a_mag  = a[W-2:0];
  assign b_mag  = b[W-2:0];

  assign a_nan = (&a[W-2:MAN_W]) & (|a[MAN_W-1:0]);
  assign b_nan = (&b[W-2:MAN_W]) & (|b[MAN_W-1:0]);

  // Zero magnitude makes the sign bit irrelevant.
  assign both_zero = (a_mag == '0) && (b_mag == '0);
  assign a_eq_b    = both_zero || (a == b);

  always_comb begin
    a_gt_b = 1'b0;
    if (both_zero) begin
      a_gt_b = 1'b0;
    end else if (a_sign != b_sign) begin
      a_gt_b = !a_sign;
    end else if (!a_sign) begin
      a_gt_b = (a_mag > b_mag);
    end else begin
      // Both negative: the larger magnitude is the smaller value.
      a_gt_b = (a_mag < b_mag);
    end
  end

endmodule

// File: rtl/float_argmax.sv
// rtl/float_argmax.sv - streaming N-element float argmax/argmin reduction
// Purpose : accepts N elements over a valid/ready stream, tracks the extreme
//           value (max or min, chosen with element 0) and its index, and
//           presents the result on a back-pressured output port.
// Ports   : clk, rst (sync, active high)
//           find_min            - 0 argmax, 1 argmin, sampled with element 0
//           in_valid/in_ready   - element handshake, in_data = {sign,exp,man}
//           out_valid/out_ready - result handshake
//           out_index, out_value, out_nan - registered result
// Config  : FLOAT_ARGMAX_NAN_EN - NaN-aware ordering and sticky out_nan;
//           when undefined NaNs order by raw bits and out_nan is 0.
module float_argmax
  import nn_fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int N     = 10,
  parameter int IDX_W = idx_width(N),
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             find_min,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [W-1:0]     out_value,
  output logic             out_nan
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     best_val_q, best_val_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             mode_q, mode_d;
  logic             nan_q, nan_d;

  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_nan;
  logic             b_nan;
  logic             better;
  logic             replace;
  logic             in_nan;
  logic             accept;
  logic             last_beat;

  fp_order_cmp #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_cmp (
    .a      (in_data),
    .b      (best_val_q),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_nan  (a_nan),
    .b_nan  (b_nan)
  );

  // Strict comparison in both modes so ties keep the earlier index.
  assign better = mode_q ? (!a_gt_b && !a_eq_b) : a_gt_b;

`ifdef FLOAT_ARGMAX_NAN_EN
  // A NaN never wins; a NaN held from element 0 yields to any real value.
  assign replace = !a_nan && (b_nan || better);
  assign in_nan  = a_nan;
`else
  logic unused_nan;
  assign unused_nan = a_nan | b_nan;
  assign replace    = better;
  assign in_nan     = 1'b0;
`endif

  assign accept    = in_valid && (state_q == S_COLLECT);
  assign last_beat = (cnt_q == IDX_W'(N - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    mode_d     = mode_q;
    nan_d      = nan_q;
    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          if (cnt_q == '0) begin
            best_val_d = in_data;
            best_idx_d = '0;
            mode_d     = find_min;
            nan_d      = in_nan;
          end else begin
            if (replace) begin
              best_val_d = in_data;
              best_idx_d = cnt_q;
            end
            nan_d = nan_q | in_nan;
          end
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_RESULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_COLLECT;
      cnt_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      mode_q     <= 1'b0;
      nan_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      mode_q     <= mode_d;
      nan_q      <= nan_d;
    end
  end

  // Result fields are the running-best registers; they cannot change in
  // RESULT because no element is accepted there.
  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_RESULT);
  assign out_index = best_idx_q;
  assign out_value = best_val_q;
  assign out_nan   = nan_q;

endmodule
